// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, MEM), the arbiter and the register file port.
// The master side drives requests and stall; the slave side (the arbiter) answers with Ready and the write.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              AluValid;
  logic [ADDR_W-1:0] AluReg;
  logic [DATA_W-1:0] AluData;
  logic              AluReady;
  logic              MemValid;
  logic [ADDR_W-1:0] MemReg;
  logic [DATA_W-1:0] MemData;
  logic              MemReady;
  logic              WbStall;
  logic              Write1;
  logic [ADDR_W-1:0] WriteReg1;
  logic [DATA_W-1:0] WriteData1;
  logic [2:0]        AluAge;

  modport master (
    output AluValid, AluReg, AluData, MemValid, MemReg, MemData, WbStall,
    input  AluReady, MemReady, Write1, WriteReg1, WriteData1, AluAge
  );

  modport slave (
    input  AluValid, AluReg, AluData, MemValid, MemReg, MemData, WbStall,
    output AluReady, MemReady, Write1, WriteReg1, WriteData1, AluAge
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between ALU and memory-load writebacks.
// Loads win ties unless the ALU has waited AGE_MAX cycles; the winning write is registered once.
module regfile_wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int AGE_MAX = 4
) (
  input logic                 CLK,
  input logic                 RESET,
  regfile_wb_arbiter_if.slave wb
);
  localparam logic [2:0] AGE_SAT = 3'(AGE_MAX);

  // Handshake: a transfer happens in any cycle where Valid && Ready; Ready is a
  // combinational function of both Valids, WbStall, AluAge and RESET, never high
  // without its own Valid, and at most one Ready is high per cycle.
  logic              w_alu_grant;
  logic              w_mem_grant;
  logic              w_grant;
  logic [ADDR_W-1:0] w_reg;
  logic [DATA_W-1:0] w_data;

  logic              r_write;
  logic [ADDR_W-1:0] r_reg;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_age;

  always_comb begin
    w_alu_grant = 1'b0;
    w_mem_grant = 1'b0;
    w_reg       = wb.MemReg;
    w_data      = wb.MemData;
    if (!RESET && !wb.WbStall) begin
      if (wb.AluValid && (!wb.MemValid || r_age == AGE_SAT)) begin
        w_alu_grant = 1'b1;
        w_reg       = wb.AluReg;
        w_data      = wb.AluData;
      end else if (wb.MemValid) begin
        w_mem_grant = 1'b1;
      end
    end
    w_grant = w_alu_grant || w_mem_grant;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_write <= 1'b0;
      r_reg   <= '0;
      r_data  <= '0;
      r_age   <= '0;
    end else begin
      // Register-0 grants are accepted but never reach the register file.
      r_write <= w_grant && (w_reg != '0);
      if (w_grant) begin
        r_reg  <= w_reg;
        r_data <= w_data;
      end
      if (w_alu_grant || !wb.AluValid) begin
        r_age <= '0;
      end else if (r_age != AGE_SAT) begin
        r_age <= r_age + 3'd1;
      end
    end
  end

  assign wb.AluReady   = w_alu_grant;
  assign wb.MemReady   = w_mem_grant;
  assign wb.Write1     = r_write;
  assign wb.WriteReg1  = r_reg;
  assign wb.WriteData1 = r_data;
  assign wb.AluAge     = r_age;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic, checked against a
// cycle-level reference model of the grant rules plus a shadow register file.
module tb_regfile_wb_arbiter;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int AGE_MAX = 4;

  logic CLK;
  logic RESET;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AGE_MAX(AGE_MAX)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .wb    (bus.slave)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int              m_age;
  bit              m_write;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_data;
  bit              m_alu_gnt;
  bit              m_mem_gnt;
  logic [DATA_W-1:0] model_rf [32];
  logic [DATA_W-1:0] dut_rf   [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full clock: drive inputs after negedge, check Ready/age, step model, check outputs.
  task automatic cycle(input bit av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                       input bit mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md,
                       input bit st, input bit rst);
    bus.AluValid = av; bus.AluReg = ar; bus.AluData = ad;
    bus.MemValid = mv; bus.MemReg = mr; bus.MemData = md;
    bus.WbStall  = st; RESET = rst;
    #1;
    m_alu_gnt = 0;
    m_mem_gnt = 0;
    if (!rst && !st) begin
      if (av && mv) begin
        if (m_age == AGE_MAX) m_alu_gnt = 1;
        else                  m_mem_gnt = 1;
      end else begin
        m_alu_gnt = av;
        m_mem_gnt = mv;
      end
    end
    chk("AluReady", 64'(bus.AluReady), 64'(m_alu_gnt));
    chk("MemReady", 64'(bus.MemReady), 64'(m_mem_gnt));
    chk("AluAge_pre", 64'(bus.AluAge), 64'(m_age));
    @(posedge CLK);
    #1;
    if (rst) begin
      m_write = 0; m_reg = '0; m_data = '0; m_age = 0;
    end else begin
      m_write = 0;
      if (m_alu_gnt) begin m_reg = ar; m_data = ad; m_write = (ar != 0); end
      if (m_mem_gnt) begin m_reg = mr; m_data = md; m_write = (mr != 0); end
      if (m_write) model_rf[m_reg] = m_data;
      if (m_alu_gnt || !av) m_age = 0;
      else if (m_age < AGE_MAX) m_age = m_age + 1;
    end
    if (bus.Write1 === 1'b1) dut_rf[bus.WriteReg1] = bus.WriteData1;
    chk("Write1", 64'(bus.Write1), 64'(m_write));
    chk("WriteReg1", 64'(bus.WriteReg1), 64'(m_reg));
    chk("WriteData1", 64'(bus.WriteData1), 64'(m_data));
    chk("AluAge_post", 64'(bus.AluAge), 64'(m_age));
    @(negedge CLK);
  endtask

  task automatic idle();
    cycle(0, '0, '0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end
    m_age = 0; m_write = 0; m_reg = '0; m_data = '0;
    bus.AluValid = 0; bus.AluReg = '0; bus.AluData = '0;
    bus.MemValid = 0; bus.MemReg = '0; bus.MemData = '0;
    bus.WbStall = 0; RESET = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    // 1: reset with both valid -> no Ready, outputs cleared
    cycle(1, 5'd7, 32'h1111, 1, 5'd8, 32'h2222, 0, 1);
    chk("t1_write1", 64'(bus.Write1), 64'd0);
    chk("t1_reg", 64'(bus.WriteReg1), 64'd0);
    chk("t1_data", 64'(bus.WriteData1), 64'd0);

    // 2: single ALU write
    cycle(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, 0);
    chk("t2_write1", 64'(bus.Write1), 64'd1);
    chk("t2_reg", 64'(bus.WriteReg1), 64'd5);
    chk("t2_data", 64'(bus.WriteData1), 64'hDEADBEEF);
    idle();
    chk("t2_write1_drop", 64'(bus.Write1), 64'd0);

    // 3: both valid -> MEM first, then ALU
    cycle(1, 5'd3, 32'd1, 1, 5'd4, 32'd2, 0, 0);
    chk("t3_first_reg", 64'(bus.WriteReg1), 64'd4);
    cycle(1, 5'd3, 32'd1, 0, '0, '0, 0, 0);
    chk("t3_second_reg", 64'(bus.WriteReg1), 64'd3);
    chk("t3_second_data", 64'(bus.WriteData1), 64'd1);
    idle();

    // 4: MEM always valid -> ALU ages 0..4, then wins
    for (int k = 0; k < AGE_MAX; k++) begin
      cycle(1, 5'd9, 32'hA0 + 32'(k), 1, 5'd10, 32'hB0 + 32'(k), 0, 0);
      chk("t4_age", 64'(bus.AluAge), 64'(k + 1));
      chk("t4_mem_reg", 64'(bus.WriteReg1), 64'd10);
    end
    cycle(1, 5'd9, 32'hAA, 1, 5'd10, 32'hBB, 0, 0);
    chk("t4_alu_win_reg", 64'(bus.WriteReg1), 64'd9);
    chk("t4_age_cleared", 64'(bus.AluAge), 64'd0);
    idle();

    // 5: MEM to reg 0 dropped; stall blocks grants; stall at saturation keeps age
    cycle(0, '0, '0, 1, 5'd0, 32'h55, 0, 0);
    chk("t5_r0_write1", 64'(bus.Write1), 64'd0);
    cycle(1, 5'd1, 32'h66, 1, 5'd2, 32'h77, 1, 0);
    chk("t5_stall_write1", 64'(bus.Write1), 64'd0);
    for (int k = 0; k < AGE_MAX + 2; k++) cycle(1, 5'd1, 32'h66, 1, 5'd2, 32'h77, 1, 0);
    chk("t5_stall_sat", 64'(bus.AluAge), 64'(AGE_MAX));
    cycle(1, 5'd1, 32'h66, 1, 5'd2, 32'h77, 0, 0);
    chk("t5_alu_first", 64'(bus.WriteReg1), 64'd1);
    idle();

    // random traffic with occasional stall and reset
    for (int n = 0; n < 400; n++) begin
      cycle(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
    end
    idle();
    for (int r = 1; r < 8; r++) chk($sformatf("rf_r%0d", r), 64'(dut_rf[r]), 64'(model_rf[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
